// File: rtl/rv_plic_claim_ctrl.sv
// PLIC gateways: each source walks IDLE -> PEND -> ACT -> IDLE, with a 1-deep edge latch,
// plus claim arbitration across targets (lowest target index wins a shared ID).
module rv_plic_claim_ctrl #(
   parameter int N_SOURCE = 32,
   parameter int N_TARGET = 2,
   localparam int SRCW = $clog2(N_SOURCE + 1)
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic [N_SOURCE-1:0]              src_i,
   input  logic [N_SOURCE-1:0]              le_i,
   output logic [N_SOURCE-1:0]              ip_o,
   output logic [N_SOURCE-1:0]              ia_o,
   input  logic [N_TARGET-1:0][SRCW-1:0]    irq_id_i,
   input  logic [N_TARGET-1:0]              claim_re_i,
   output logic [N_TARGET-1:0]              claim_ack_o,
   output logic [N_TARGET-1:0][SRCW-1:0]    claim_id_o,
   input  logic [N_TARGET-1:0]              complete_we_i,
   input  logic [N_TARGET-1:0][SRCW-1:0]    complete_id_i
);
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PEND = 2'b10,
      ACT  = 2'b01
   } src_state_e;

   logic [N_TARGET-1:0][N_SOURCE-1:0] claim_hit;
   logic [N_TARGET-1:0][N_SOURCE-1:0] claim_grant;
   logic [N_SOURCE-1:0]               claim_taken;
   logic [N_SOURCE-1:0]               complete_hit;
   logic [N_TARGET-1:0]               claim_ack_reg;
   logic [N_TARGET-1:0][SRCW-1:0]     claim_id_reg;
   logic [N_TARGET-1:0][SRCW-1:0]     claim_id_next;

   genvar gi, gj;

   // A claim only hits a source that is pending; ID 0 and out-of-range IDs match nothing.
   generate
      for (gi = 0; gi < N_TARGET; gi++) begin : g_tgt
         for (gj = 0; gj < N_SOURCE; gj++) begin : g_hit
            assign claim_hit[gi][gj] = claim_re_i[gi] && ip_o[gj] &&
                                       (irq_id_i[gi] == SRCW'(gj + 1));
         end
         assign claim_id_next[gi] = (|claim_grant[gi]) ? irq_id_i[gi] : '0;
      end
   endgenerate

   always_comb begin
      claim_taken = '0;
      claim_grant = '0;
      for (int t = 0; t < N_TARGET; t++) begin
         claim_grant[t] = claim_hit[t] & ~claim_taken;
         claim_taken    = claim_taken | claim_hit[t];
      end
   end

   always_comb begin
      complete_hit = '0;
      for (int t = 0; t < N_TARGET; t++) begin
         for (int s = 0; s < N_SOURCE; s++) begin
            if (complete_we_i[t] && (complete_id_i[t] == SRCW'(s + 1))) begin
               complete_hit[s] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         claim_ack_reg <= '0;
         claim_id_reg  <= '0;
      end else begin
         claim_ack_reg <= claim_re_i;
         claim_id_reg  <= claim_id_next;
      end
   end

   assign claim_ack_o = claim_ack_reg;
   assign claim_id_o  = claim_id_reg;

   generate
      for (gi = 0; gi < N_SOURCE; gi++) begin : g_src
         src_state_e state_reg;
         logic       edge_latch_reg;
         logic       src_q_reg;
         logic       rise;
         logic       set_cond;

         assign rise     = src_i[gi] & ~src_q_reg;
         assign set_cond = le_i[gi] ? (rise | edge_latch_reg) : src_i[gi];
         assign ip_o[gi] = (state_reg == PEND);
         assign ia_o[gi] = (state_reg == ACT);

         always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
               state_reg      <= IDLE;
               edge_latch_reg <= 1'b0;
               src_q_reg      <= 1'b0;
            end else begin
               src_q_reg <= src_i[gi];
               case (state_reg)
                  IDLE: begin
                     if (set_cond) begin
                        state_reg      <= PEND;
                        edge_latch_reg <= 1'b0;
                     end
                  end
                  PEND: begin
                     if (claim_taken[gi]) state_reg <= ACT;
                     if (le_i[gi] && rise) edge_latch_reg <= 1'b1;
                  end
                  ACT: begin
                     // Completion always lands in IDLE; a held edge re-pends from there.
                     if (complete_hit[gi]) state_reg <= IDLE;
                     if (le_i[gi] && rise) edge_latch_reg <= 1'b1;
                  end
                  default: state_reg <= IDLE;
               endcase
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_rv_plic_claim_ctrl.sv
// Randomized bench for rv_plic_claim_ctrl: driver feeds a per-source reference model and
// queues expected outputs; a monitor pops one expectation per clock and compares.
module tb_rv_plic_claim_ctrl;
   localparam int NS   = 32;
   localparam int NT   = 2;
   localparam int SW   = $clog2(NS + 1);
   localparam int NCYC = 1500;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [NS-1:0]           src, le, ip, ia;
   logic [NT-1:0][SW-1:0]   irq_id, claim_id, complete_id;
   logic [NT-1:0]           claim_re, claim_ack, complete_we;

   always #5 clk = ~clk;

   rv_plic_claim_ctrl #(.N_SOURCE(NS), .N_TARGET(NT)) dut (
      .clk_i(clk), .rst_ni(rst_n), .src_i(src), .le_i(le), .ip_o(ip), .ia_o(ia),
      .irq_id_i(irq_id), .claim_re_i(claim_re), .claim_ack_o(claim_ack),
      .claim_id_o(claim_id), .complete_we_i(complete_we), .complete_id_i(complete_id)
   );

   typedef struct {
      logic [NS-1:0]         ip;
      logic [NS-1:0]         ia;
      logic [NT-1:0]         ack;
      logic [NT-1:0][SW-1:0] id;
      int                    cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   exp_t drv_e;
   int   total = 0;
   int   bad   = 0;

   // Reference model: one pending flag, one active flag and one held edge per source.
   bit m_pend[NS];
   bit m_act[NS];
   bit m_latch[NS];
   bit m_prev[NS];

   task automatic chk(input string nm, input int idx, input int cyc,
                      input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s[%0d] cyc=%0d got=%h expected=%h", nm, idx, cyc, got, want);
      end
   endtask

   task automatic model_step(output exp_t e);
      bit taken[NS];
      bit done[NS];
      int id;
      bit rise;
      e.ip = '0; e.ia = '0; e.ack = '0; e.id = '0; e.cyc = 0;
      for (int s = 0; s < NS; s++) begin
         taken[s] = 1'b0;
         done[s]  = 1'b0;
      end
      if (!rst_n) begin
         for (int s = 0; s < NS; s++) begin
            m_pend[s] = 1'b0; m_act[s] = 1'b0; m_latch[s] = 1'b0; m_prev[s] = 1'b0;
         end
      end else begin
         for (int t = 0; t < NT; t++) begin
            if (claim_re[t]) begin
               e.ack[t] = 1'b1;
               id = int'(irq_id[t]);
               if (id >= 1 && id <= NS && m_pend[id-1] && !taken[id-1]) begin
                  taken[id-1] = 1'b1;
                  e.id[t] = SW'(id);
               end
            end
         end
         for (int t = 0; t < NT; t++) begin
            id = int'(complete_id[t]);
            if (complete_we[t] && id >= 1 && id <= NS && m_act[id-1]) done[id-1] = 1'b1;
         end
         for (int s = 0; s < NS; s++) begin
            rise = src[s] && !m_prev[s];
            if (m_pend[s]) begin
               if (taken[s]) begin m_pend[s] = 1'b0; m_act[s] = 1'b1; end
               if (le[s] && rise) m_latch[s] = 1'b1;
            end else if (m_act[s]) begin
               if (done[s]) m_act[s] = 1'b0;
               if (le[s] && rise) m_latch[s] = 1'b1;
            end else if (le[s] ? (rise || m_latch[s]) : src[s]) begin
               m_pend[s]  = 1'b1;
               m_latch[s] = 1'b0;
            end
            m_prev[s] = src[s];
         end
      end
      for (int s = 0; s < NS; s++) begin
         e.ip[s] = m_pend[s];
         e.ia[s] = m_act[s];
      end
   endtask

   function automatic logic [SW-1:0] pick_id(input int lst[$], input int r);
      if (r < 6 && lst.size() > 0) return SW'(lst[$urandom_range(0, lst.size() - 1)]);
      if (r == 6) return '0;
      if (r == 7) return SW'($urandom_range(NS + 1, (1 << SW) - 1));
      return SW'($urandom_range(1, NS));
   endfunction

   task automatic gen_inputs();
      int pl[$];
      int al[$];
      for (int s = 0; s < NS; s++) begin
         if (m_pend[s]) pl.push_back(s + 1);
         if (m_act[s])  al.push_back(s + 1);
         if ($urandom_range(0, 5) == 0) src[s] = ~src[s];
      end
      for (int t = 0; t < NT; t++) begin
         claim_re[t]    = ($urandom_range(0, 2) == 0);
         irq_id[t]      = pick_id(pl, int'($urandom_range(0, 9)));
         complete_we[t] = ($urandom_range(0, 3) == 0);
         complete_id[t] = pick_id(al, int'($urandom_range(0, 9)));
      end
      // Claim race: every target asks for the same ID in one cycle.
      if ($urandom_range(0, 5) == 0) begin
         claim_re = '1;
         for (int t = 1; t < NT; t++) irq_id[t] = irq_id[0];
      end
   endtask

   initial begin
      rst_n = 1'b0; src = '0; le = '0; claim_re = '0; irq_id = '0;
      complete_we = '0; complete_id = '0;
      for (int c = 0; c < NCYC; c++) begin
         @(negedge clk);
         rst_n = !(c < 2 || c == 600 || c == 1200);
         if (!rst_n) begin
            for (int s = 0; s < NS; s++) le[s] = 1'($urandom_range(0, 1));
         end
         gen_inputs();
         model_step(drv_e);
         drv_e.cyc = c;
         exp_q.push_back(drv_e);
      end
      @(negedge clk);
      claim_re = '0;
      complete_we = '0;
      for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
      chk("drain", 0, NCYC, 64'(exp_q.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("ip_o", 0, mon_e.cyc, 64'(ip), 64'(mon_e.ip));
         chk("ia_o", 0, mon_e.cyc, 64'(ia), 64'(mon_e.ia));
         for (int t = 0; t < NT; t++) begin
            chk("claim_ack_o", t, mon_e.cyc, 64'(claim_ack[t]), 64'(mon_e.ack[t]));
            chk("claim_id_o", t, mon_e.cyc, 64'(claim_id[t]), 64'(mon_e.id[t]));
            if (mon_e.ack[t])
               $display("claim cyc=%0d target=%0d id=%0d expected_id=%0d",
                        mon_e.cyc, t, claim_id[t], mon_e.id[t]);
         end
      end
   end

endmodule

// File: doc/rv_plic_claim_ctrl.md
Name: rv_plic_claim_ctrl

Overview:
Per-source interrupt gateway and claim/complete sequencer for the PLIC.
- Converts raw level- or edge-triggered source lines into pending bits (ip_o).
- Feeds the per-target priority/threshold selectors, which return a winning ID per target.
- Arbitrates claim reads and complete writes from all targets, so each interrupt is delivered to exactly one target and cannot re-fire until completed.

Parameters:
N_SOURCE, 32, number of interrupt sources (IDs 1..N_SOURCE; ID 0 = none)
N_TARGET, 2, number of targets (harts/contexts)
SRCW, $clog2(N_SOURCE+1), ID width (localparam, do not override)

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
src_i  in  N_SOURCE  raw interrupt lines, already synchronised to clk_i
le_i  in  N_SOURCE  trigger mode per source: 1 = edge, 0 = level
ip_o  out  N_SOURCE  registered pending bits, to target selectors
ia_o  out  N_SOURCE  registered in-service (claimed, not completed) bits
irq_id_i  in  N_TARGET x SRCW  current best ID from each target selector
claim_re_i  in  N_TARGET  single-cycle claim-read strobe per target
claim_ack_o  out  N_TARGET  claim response valid, one cycle after claim_re_i
claim_id_o  out  N_TARGET x SRCW  claimed ID, valid with claim_ack_o, else 0
complete_we_i  in  N_TARGET  single-cycle complete-write strobe per target
complete_id_i  in  N_TARGET x SRCW  ID being completed

Behaviour:
Reset: synchronous, active-low, on clk_i. While rst_ni=0, next edge clears all of: ip_o, ia_o, claim_ack_o, claim_id_o, edge latches, src_q.
- Because src_q resets to 0, a src_i already high in edge mode counts as an edge in the first cycle after reset.

Per-source FSM: IDLE (ip=0, ia=0), PEND (ip=1, ia=0), ACT (ip=0, ia=1). ip=ia=1 is illegal.
- Set condition: level mode = src_i; edge mode = (src_i & ~src_q) | edge_latch.
- IDLE -> PEND: set condition true. Clears edge_latch.
- PEND -> ACT: granted claim hits this ID.
- ACT -> IDLE: any target completes this ID.
  - No direct ACT -> PEND; re-evaluation happens in IDLE on the next cycle.
  - A level source still high is therefore pending again 2 cycles after the complete strobe.
- Edge mode: a rising edge seen in PEND or ACT sets edge_latch (depth 1; further edges are lost).
- Level mode: edge_latch is never set. A level source dropping while PEND stays PEND; there is no retraction.
- le_i changes affect only future set evaluations, never the current state.

Claim:
- On claim_re_i[t], sample irq_id_i[t] in the same cycle.
- Grant if the ID is in 1..N_SOURCE and that source is in PEND.
- Multiple targets claiming the same ID in one cycle: lowest target index wins; the others get 0.
- Next cycle: claim_ack_o[t]=1 and claim_id_o[t] = granted ID, or 0 if not granted.
  - The source shows ACT (ip_o=0, ia_o=1) in that same cycle.
- claim_ack_o is a 1-cycle pulse. claim_id_o returns to 0 when ack is low.
- Back-to-back claims from the same target are allowed every cycle.

Complete:
- complete_we_i[t] with ID in 1..N_SOURCE and that source in ACT moves it to IDLE next cycle.
- Otherwise ignored: ID 0, ID > N_SOURCE, or source not in ACT. No error signalled.
- Any target may complete any ID; the claiming target is not tracked.
- Several completes in one cycle are applied together (OR).

Simultaneous events:
- Claim and complete on the same source cannot both apply, since they require different states.
- Claim and new edge in the same cycle: claim wins, edge is latched.
- Complete and new edge in the same cycle: go to IDLE with edge_latch set, then PEND next cycle.

Latency:
- src_i to ip_o: 1 cycle.
- claim_re_i to claim_ack_o: 1 cycle.
- complete_we_i to ia_o=0: 1 cycle.

Test Plan:
1. Level, le=0, src[4]=1 held: ip_o[4]=1 after 1 cycle. T0 claims with irq_id_i=5 -> ack next cycle, claim_id_o[0]=5, ip[4]=0, ia[4]=1. Complete ID 5 -> ia[4]=0, and ip[4]=1 again 2 cycles after the strobe.
2. Edge, le[0]=1: three pulses on src[0] while in ACT -> after complete ID 1, ip[0]=1 exactly once. Second claim/complete cycle -> ip[0] stays 0.
3. Claim race: T0 and T1 both claim ID 3 in one cycle -> claim_id_o[0]=3, claim_id_o[1]=0, both acks=1.
4. Invalid accesses:
   - Claim with irq_id_i=0 -> ack=1, id=0.
   - Complete IDs 0, N_SOURCE+1, and an IDLE source -> no state change.
5. Reset mid-operation: rst_ni=0 for 1 cycle while source 7 is ACT and claim_ack pending -> next cycle all outputs 0. With src[6] high in edge mode -> ip[6]=1 one cycle after reset release.
6. Complete and edge same cycle on edge source 2 -> ia[2]=0 next cycle, ip[2]=1 the cycle after.
